// File: rtl/stopwatch_bcd_pkg.sv
// Shared types and constants for the MM:SS.cc stopwatch core.
// Digit index 0 is centisecond units, 5 is minute tens.
package stopwatch_pkg;
  localparam int DIGIT_W    = 4;
  localparam int MOD_DEC    = 10;
  localparam int MOD_SIX    = 6;
  localparam int NUM_DIGITS = 6;

  typedef logic [DIGIT_W-1:0] bcd_t;
  typedef bcd_t [NUM_DIGITS-1:0] time_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSED = 2'b10
  } state_t;

  localparam time_t MAX_TIME = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

  // Seconds tens and minutes tens count to 5; every other digit counts to 9.
  function automatic int digit_mod(input int idx);
    return (idx == 3 || idx == 5) ? MOD_SIX : MOD_DEC;
  endfunction
endpackage

// File: rtl/stopwatch_bcd_if.sv
// Control pulses in and display digits/status out for the stopwatch core.
interface stopwatch_bcd_if;
  import stopwatch_pkg::*;
  logic tick, start_stop, clear, lap;
  bcd_t cs_ones, cs_tens, s_ones, s_tens, m_ones, m_tens;
  logic running, lap_active, overflow;

  modport master (
    output tick, start_stop, clear, lap,
    input  cs_ones, cs_tens, s_ones, s_tens, m_ones, m_tens,
    input  running, lap_active, overflow
  );
  modport slave (
    input  tick, start_stop, clear, lap,
    output cs_ones, cs_tens, s_ones, s_tens, m_ones, m_tens,
    output running, lap_active, overflow
  );
endinterface

// File: rtl/stopwatch_bcd_digit_counter.sv
// One BCD digit counting 0..MODULUS-1; carry fires on the wrapping increment.
// q_nxt exposes the value being loaded so the parent can register its display.
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter int MODULUS = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output bcd_t q,
  output bcd_t q_nxt,
  output logic carry
);
  assign carry = inc && (q == bcd_t'(MODULUS - 1));

  always_comb begin
    q_nxt = q;
    if (clr)      q_nxt = '0;
    else if (inc) q_nxt = carry ? '0 : q + bcd_t'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= '0;
    else       q <= q_nxt;
  end
endmodule

// File: rtl/stopwatch_bcd.sv
// Centisecond stopwatch: run/pause/clear FSM, six chained BCD digits,
// lap freeze register and a registered display mux.
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter bit ROLLOVER = 1'b1
) (
  input logic             clk,
  input logic             reset,
  stopwatch_bcd_if.slave  sw
);
  state_t                r_state;
  logic                  r_running, r_ovf, r_la;
  time_t                 r_lap, r_disp;
  time_t                 w_live, w_live_nxt, w_lap_nxt;
  logic                  w_la_nxt;
  logic [NUM_DIGITS:0]   w_carry;
  logic                  w_tick_run, w_at_max, w_sat;

  assign w_tick_run = sw.tick && (r_state == RUN) && !sw.clear;
  assign w_at_max   = (w_live == MAX_TIME);
  // Without rollover the count sticks at the max instead of wrapping.
  assign w_sat      = !ROLLOVER && w_at_max;
  assign w_carry[0] = w_tick_run && !w_sat;

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_dig
      bcd_digit_counter #(.MODULUS(digit_mod(g))) u_dig (
        .clk   (clk),
        .reset (reset),
        .clr   (sw.clear),
        .inc   (w_carry[g]),
        .q     (w_live[g]),
        .q_nxt (w_live_nxt[g]),
        .carry (w_carry[g+1])
      );
    end
  endgenerate

  // Lap captures the pre-increment count, so it samples w_live, not w_live_nxt.
  always_comb begin
    w_lap_nxt = r_lap;
    w_la_nxt  = r_la;
    if (sw.clear) begin
      w_lap_nxt = '0;
      w_la_nxt  = 1'b0;
    end else if (sw.lap && r_state != IDLE) begin
      if (!r_la) begin
        w_lap_nxt = w_live;
        w_la_nxt  = 1'b1;
      end else begin
        w_la_nxt  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
      r_ovf     <= 1'b0;
      r_la      <= 1'b0;
      r_lap     <= '0;
      r_disp    <= '0;
    end else begin
      r_lap  <= w_lap_nxt;
      r_la   <= w_la_nxt;
      r_disp <= w_la_nxt ? w_lap_nxt : w_live_nxt;
      if (sw.clear) begin
        r_state   <= IDLE;
        r_running <= 1'b0;
        r_ovf     <= 1'b0;
      end else begin
        if (w_carry[NUM_DIGITS] || (w_tick_run && w_sat)) r_ovf <= 1'b1;
        if (w_tick_run && w_sat) begin
          r_state   <= PAUSED;
          r_running <= 1'b0;
        end else if (sw.start_stop) begin
          if (r_state == RUN) begin
            r_state   <= PAUSED;
            r_running <= 1'b0;
          end else begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end
        end
      end
    end
  end

  assign sw.cs_ones    = r_disp[0];
  assign sw.cs_tens    = r_disp[1];
  assign sw.s_ones     = r_disp[2];
  assign sw.s_tens     = r_disp[3];
  assign sw.m_ones     = r_disp[4];
  assign sw.m_tens     = r_disp[5];
  assign sw.running    = r_running;
  assign sw.lap_active = r_la;
  assign sw.overflow   = r_ovf;
endmodule

// File: tb/tb_stopwatch_bcd.sv
// Bench for stopwatch_bcd: both ROLLOVER variants driven in parallel, each
// checked every cycle against an integer-centisecond model plus literal checkpoints.
module tb_stopwatch_bcd;
  import stopwatch_pkg::*;

  localparam int TMAX = 359999;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tk = 1'b0, ss = 1'b0, cl = 1'b0, lp = 1'b0;
  always #5 clk = ~clk;

  stopwatch_bcd_if if1 ();
  stopwatch_bcd_if if0 ();
  assign if1.tick = tk; assign if1.start_stop = ss; assign if1.clear = cl; assign if1.lap = lp;
  assign if0.tick = tk; assign if0.start_stop = ss; assign if0.clear = cl; assign if0.lap = lp;

  stopwatch_bcd #(.ROLLOVER(1'b1)) dut1 (.clk(clk), .reset(rst), .sw(if1.slave));
  stopwatch_bcd #(.ROLLOVER(1'b0)) dut0 (.clk(clk), .reset(rst), .sw(if0.slave));

  logic [23:0] d1, d0;
  logic [2:0]  f1, f0;
  assign d1 = {if1.m_tens, if1.m_ones, if1.s_tens, if1.s_ones, if1.cs_tens, if1.cs_ones};
  assign d0 = {if0.m_tens, if0.m_ones, if0.s_tens, if0.s_ones, if0.cs_tens, if0.cs_ones};
  assign f1 = {if1.running, if1.lap_active, if1.overflow};
  assign f0 = {if0.running, if0.lap_active, if0.overflow};

  // Model: st 0=idle 1=run 2=paused; t and lap in whole centiseconds.
  typedef struct {
    int t; int st; int lap; bit la; bit ov;
  } mdl_t;
  mdl_t m1, m0;

  function automatic mdl_t step(mdl_t m, bit ro, bit itk, bit iss, bit icl, bit ilp);
    mdl_t n;
    bit   sat;
    n   = m;
    sat = 1'b0;
    if (icl) begin
      n = '{0, 0, 0, 1'b0, 1'b0};
      return n;
    end
    if (m.st == 1 && itk) begin
      if (m.t == TMAX) begin
        n.ov = 1'b1;
        if (ro) n.t = 0;
        else begin n.st = 2; sat = 1'b1; end
      end else n.t = m.t + 1;
    end
    if (iss && !sat) n.st = (m.st == 1) ? 2 : 1;
    if (ilp && m.st != 0) begin
      if (!m.la) begin n.lap = m.t; n.la = 1'b1; end
      else n.la = 1'b0;
    end
    return n;
  endfunction

  function automatic logic [23:0] pack(input int t);
    int m, s, c;
    m = t / 6000; s = (t / 100) % 60; c = t % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  function automatic logic [23:0] exp_d(input mdl_t m);
    return pack(m.la ? m.lap : m.t);
  endfunction

  function automatic logic [23:0] exp_f(input mdl_t m);
    return {21'd0, (m.st == 1), m.la, m.ov};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m1 <= '{0, 0, 0, 1'b0, 1'b0};
      m0 <= '{0, 0, 0, 1'b0, 1'b0};
    end else begin
      m1 <= step(m1, 1'b1, tk, ss, cl, lp);
      m0 <= step(m0, 1'b0, tk, ss, cl, lp);
    end
  end

  int errs = 0, checks = 0;

  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("ro1_digits", d1, exp_d(m1));
      chk("ro1_flags", {21'd0, f1}, exp_f(m1));
      chk("ro0_digits", d0, exp_d(m0));
      chk("ro0_flags", {21'd0, f0}, exp_f(m0));
    end
  end

  task automatic cyc(input bit itk, input bit iss, input bit icl, input bit ilp);
    tk = itk; ss = iss; cl = icl; lp = ilp;
    @(posedge clk); #1;
    tk = 1'b0; ss = 1'b0; cl = 1'b0; lp = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_d1", d1, 24'h0); chk("rst_f1", {21'd0, f1}, 24'h0);
    chk("rst_d0", d0, 24'h0); chk("rst_f0", {21'd0, f0}, 24'h0);

    cyc(0, 1, 0, 0); ticks(150);
    chk("run150_d", d1, 24'h000150); chk("run150_f", {21'd0, f1}, 24'h4);

    cyc(0, 0, 1, 0); cyc(0, 1, 0, 0); ticks(99); cyc(1, 1, 0, 0);
    chk("ss_tick_d", d1, 24'h000100); chk("ss_tick_f", {21'd0, f1}, 24'h0);
    ticks(10);
    chk("paused_drop_d", d1, 24'h000100);

    cyc(0, 0, 1, 0); cyc(0, 1, 0, 0); ticks(1234); cyc(0, 0, 0, 1); ticks(200);
    chk("lap_hold_d", d1, 24'h001234); chk("lap_hold_f", {21'd0, f1}, 24'h6);
    cyc(0, 0, 0, 1);
    chk("lap_rel_d", d1, 24'h001434); chk("lap_rel_f", {21'd0, f1}, 24'h4);
    cyc(1, 0, 0, 1);
    chk("lap_tick_cap_d", d1, 24'h001434); chk("lap_tick_cap_f", {21'd0, f1}, 24'h6);
    cyc(1, 0, 0, 1);
    chk("lap_tick_rel_d", d1, 24'h001436);

    cyc(0, 0, 1, 0); cyc(0, 1, 0, 0); ticks(TMAX + 1);
    chk("wrap_d", d1, 24'h000000); chk("wrap_f", {21'd0, f1}, 24'h5);
    chk("sat_d", d0, 24'h595999); chk("sat_f", {21'd0, f0}, 24'h1);
    cyc(0, 1, 0, 0);
    chk("sat_rerun_f", {21'd0, f0}, 24'h5); chk("wrap_pause_f", {21'd0, f1}, 24'h1);
    cyc(1, 0, 0, 0);
    chk("sat_repause_d", d0, 24'h595999); chk("sat_repause_f", {21'd0, f0}, 24'h1);

    cyc(0, 1, 0, 0); ticks(500); cyc(0, 0, 0, 1);
    chk("pre_clr_d", d1, 24'h000500); chk("pre_clr_f", {21'd0, f1}, 24'h7);
    cyc(1, 1, 1, 0);
    chk("clr_d1", d1, 24'h0); chk("clr_f1", {21'd0, f1}, 24'h0);
    chk("clr_d0", d0, 24'h0); chk("clr_f0", {21'd0, f0}, 24'h0);

    cyc(0, 1, 0, 0); ticks(37);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_d", d1, 24'h0); chk("async_rst_f", {21'd0, f1}, 24'h0);
    @(posedge clk); #1 rst = 1'b0;
    cyc(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/stopwatch_bcd.md
Name: stopwatch_bcd

Overview:
- Centisecond stopwatch core, directly downstream of the 100 Hz tick divider.
- Consumes the single-cycle `tick` pulse and counts MM:SS.cc in six BCD digits.
- Run/pause/clear control FSM plus a lap-freeze display register.
- Digit outputs feed the seven-segment/VGA text renderer.

Parameters:
- ROLLOVER, 1: 1 = wrap 59:59.99 -> 00:00.00 and keep running; 0 = saturate at 59:59.99 and enter PAUSED.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- tick  input  1  one-clk-wide 100 Hz pulse from the clock divider
- start_stop  input  1  one-clk pulse; toggles run/pause
- clear  input  1  one-clk pulse; zero count, leave lap, go IDLE
- lap  input  1  one-clk pulse; toggles lap freeze
- cs_ones  output  4  centiseconds units, BCD 0-9
- cs_tens  output  4  centiseconds tens, BCD 0-9
- s_ones  output  4  seconds units, BCD 0-9
- s_tens  output  4  seconds tens, BCD 0-5
- m_ones  output  4  minutes units, BCD 0-9
- m_tens  output  4  minutes tens, BCD 0-5
- running  output  1  high in RUN state
- lap_active  output  1  display frozen at lap capture
- overflow  output  1  sticky; set on passing 59:59.99

Behaviour:
- Reset (async, active-high), all outputs and state cleared:
  - All digits 0.
  - State IDLE.
  - running, lap_active and overflow all 0.
  - Lap register 0.
- Clocking: all logic on posedge clk. All outputs registered; no combinational input-to-output paths.
- FSM states and transitions:
  - IDLE: start_stop -> RUN.
  - RUN: start_stop -> PAUSED.
  - PAUSED: start_stop -> RUN.
  - Any state: clear -> IDLE.
- running = (state == RUN), registered alongside the state.
- Counting:
  - Only in RUN, only on the tick cycle.
  - Live count is visible on outputs the cycle after tick, unless lap_active.
  - Digit chain is cs_ones (mod 10) -> cs_tens (mod 10) -> s_ones (mod 10) -> s_tens (mod 6) -> m_ones (mod 10) -> m_tens (mod 6).
  - Each digit increments when all lower digits are at their maximum and tick is valid.
- Boundary at 59:59.99 + tick:
  - ROLLOVER=1: count goes to 00:00.00, overflow <= 1, stays in RUN.
  - ROLLOVER=0: count holds 59:59.99, overflow <= 1, state -> PAUSED.
  - Further start_stop with the count at the max: RUN is re-entered, the next tick re-pauses, count unchanged.
- Lap:
  - RUN/PAUSED with lap_active=0: lap pulse captures the current live count into the lap register (value before any same-cycle increment) and sets lap_active.
  - Lap pulse while lap_active=1: clears lap_active.
  - Ignored in IDLE.
  - Counting continues underneath while frozen.
  - Outputs show the lap register when lap_active=1, live count otherwise.
- Clear:
  - Zeros the live count and lap register, clears lap_active and overflow, state -> IDLE.
  - Takes effect the next cycle.
- Simultaneous events:
  - clear has priority over everything; tick, start_stop and lap are ignored that cycle.
  - tick + start_stop: increment uses the state at the start of the cycle. Counted if in RUN (then pause); not counted if in IDLE/PAUSED (then run).
  - tick + lap in RUN: lap captures the pre-increment value; live count still increments.
  - tick + lap when lap_active=1: freeze released, live count increments, outputs show the new live value.
- Reset mid-operation: asynchronous, immediate return to the reset values above.
- Ticks while IDLE/PAUSED are dropped; no accumulation.

Decomposition:
- Shared package (stopwatch_pkg):
  - BCD digit width constant (4).
  - Digit modulus constants (10, 6).
  - FSM state enum IDLE/RUN/PAUSED, 2-bit encoding 00/01/10.
- Sub-module bcd_digit_counter:
  - Parameter MODULUS.
  - Inputs: clk, reset, clr, inc.
  - Outputs: 4-bit q, carry (q == MODULUS-1 && inc).
  - Instantiated six times, chained through carry.

Test Plan:
- Reset, start_stop, 150 ticks -> digits 00:01.50, running=1, overflow=0.
- Run, 99 ticks, start_stop+tick same cycle -> 00:01.00, running=0; 10 more ticks -> unchanged 00:01.00.
- Run to 00:12.34, lap, 200 ticks -> outputs hold 00:12.34 with lap_active=1; lap again -> outputs show 00:14.34.
- ROLLOVER=1, 360000 ticks from zero in RUN -> 00:00.00, overflow=1, running=1.
- ROLLOVER=0, 360000 ticks -> 59:59.99, overflow=1, running=0; one more start_stop + tick -> still 59:59.99, running=0.
- clear+start_stop+tick same cycle at 00:05.00 with lap_active=1 -> next cycle 00:00.00, IDLE, lap_active=0, overflow=0; async reset mid-run -> all outputs 0 immediately.
